// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer: parallel-in / serial-out framer feeding a serial
// pattern detector. Words arrive over a valid/ready handshake into a single
// holding register. Bits leave as a registered stream with first/last-bit
// strobes and an optional idle gap between frames.
//
// Optional build macro PISO_FRAME_PARITY_EN: appends one even-parity bit
// (XOR of the data bits) after the data, so a frame is WIDTH+1 bits long.
//
// state | meaning
// IDLE  | no frame on the wire; start one as soon as the hold register is full
// SHIFT | one frame bit per cycle; bit_cnt_q counts the bits still to send
// GAP   | forced idle between frames; gap_cnt_q counts remaining gap cycles

module piso_frame_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

`ifdef PISO_FRAME_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = WIDTH + PAR_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
`ifdef PISO_FRAME_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             start;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] hold_shifted;
    logic [WIDTH-1:0] shreg_shifted;

    // The holding register can only refill on the edge after it was emptied.
    assign load_ready = !hold_full_q && !rst;
    assign accept     = load_valid && load_ready;

    // The shift register always keeps the next bit to send at the exit end.
    assign first_bit     = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
    assign hold_shifted  = MSB_FIRST ? (hold_q << 1) : (hold_q >> 1);
    assign next_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // Next-state and next-output logic; outputs default to the idle line.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        ser_out_d     = IDLE_LEVEL;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
`ifdef PISO_FRAME_PARITY_EN
        parity_d      = parity_q;
`endif
        start         = 1'b0;

        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) start = 1'b1;
            end
            S_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    ser_valid_d = 1'b1;
`ifdef PISO_FRAME_PARITY_EN
                    ser_out_d   = (bit_cnt_q == CNT_ONE) ? parity_q : next_bit;
`else
                    ser_out_d   = next_bit;
`endif
                    shreg_d     = shreg_shifted;
                    bit_cnt_d   = bit_cnt_q - CNT_ONE;
                    frame_end_d = (bit_cnt_q == CNT_ONE);
                end else if (HAS_GAP) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (hold_full_q) begin
                    start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q != 4'd0) begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end else if (hold_full_q) begin
                    start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A frame start moves the held word into the shifter and shows bit 0.
        if (start) begin
            state_d       = S_SHIFT;
            hold_full_d   = 1'b0;
            shreg_d       = hold_shifted;
            bit_cnt_d     = CNT_LOAD;
            ser_out_d     = first_bit;
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
`ifdef PISO_FRAME_PARITY_EN
            parity_d      = ^hold_q;
`endif
        end
    end

    // State and output registers; reset aborts any frame and drops the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= 4'd0;
            ser_out_q     <= IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
`ifdef PISO_FRAME_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
`ifdef PISO_FRAME_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer. Four lanes with different parameter sets
// share clk/rst; each lane has a scoreboard that queues the expected bits of
// a word when it is accepted and checks them as the serial stream appears.

module tb_piso_frame_serializer;

`ifdef PISO_FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL8 = 8 + PAR;
    localparam int FL2 = 2 + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [4];
    logic [3:0] lv, lr, so, sv, fs, fe, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lanes: 0 = W8 MSB gap0 idle0, 1 = W8 LSB gap3 idle1,
    //        2 = W8 MSB gap3 idle0, 3 = W2 MSB gap0 idle0
    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam int W_K    = (k == 3) ? 2 : 8;
        localparam bit MSB_K  = (k == 1) ? 1'b0 : 1'b1;
        localparam int GAP_K  = (k == 1 || k == 2) ? 3 : 0;
        localparam bit IDLE_K = (k == 1) ? 1'b1 : 1'b0;
        localparam int FL_K   = W_K + PAR;

        logic [W_K-1:0] d_k;
        logic [2:0]     exp_q[$];
        logic [2:0]     e;
        int n_start = 0, n_end = 0, last_run = 0, last_gap = -1;
        int run = 0, idle_run = 0, pend = 0;
        bit in_run = 1'b0, has_run = 1'b0;

        assign d_k = din[k][W_K-1:0];

        piso_frame_serializer #(
            .WIDTH(W_K), .MSB_FIRST(MSB_K), .GAP_CYCLES(GAP_K), .IDLE_LEVEL(IDLE_K)
        ) u_dut (
            .clk(clk), .rst(rst), .data_in(d_k), .load_valid(lv[k]),
            .load_ready(lr[k]), .ser_out(so[k]), .ser_valid(sv[k]),
            .frame_start(fs[k]), .frame_end(fe[k]), .busy(busy[k])
        );

        always @(negedge clk) begin
            if (sv[k]) begin
                if (exp_q.size() == 0) begin
                    check_eq($sformatf("lane%0d_unexpected_bit_pending", k), 32'(exp_q.size()), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("lane%0d_bit{out,start,end}", k),
                             32'({so[k], fs[k], fe[k]}), 32'(e));
                end
                check_eq($sformatf("lane%0d_busy_in_frame", k), 32'(busy[k]), 32'(1));
                if (fs[k]) n_start++;
                if (fe[k]) n_end++;
                if (!in_run) begin
                    if (has_run) last_gap = idle_run;
                    in_run = 1'b1;
                    run = 0;
                end
                run++;
            end else begin
                check_eq($sformatf("lane%0d_idle{out,start,end}", k),
                         32'({so[k], fs[k], fe[k]}), 32'({IDLE_K, 2'b00}));
                if (in_run) begin
                    last_run = run;
                    in_run   = 1'b0;
                    has_run  = 1'b1;
                    idle_run = 0;
                end
                idle_run++;
            end

            if (rst) begin
                exp_q.delete();
                in_run   = 1'b0;
                has_run  = 1'b0;
                idle_run = 0;
            end else if (lv[k] && lr[k]) begin
                for (int i = 0; i < W_K; i++) begin
                    exp_q.push_back({(MSB_K ? d_k[W_K-1-i] : d_k[i]), (i == 0), (i == FL_K - 1)});
                end
`ifdef PISO_FRAME_PARITY_EN
                exp_q.push_back({^d_k, 1'b0, 1'b1});
`endif
            end
            pend = exp_q.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Offers one word and returns 1 ns after the edge that accepted it.
    task automatic send(input int k, input logic [7:0] d, output int waited);
        int n;
        n = 0;
        din[k] = d;
        lv[k]  = 1'b1;
        @(negedge clk);
        while (!lr[k] && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check_eq("send_timeout", 32'(n), 32'(0));
        step();
        lv[k]  = 1'b0;
        waited = n;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy[k] || sv[k]) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) check_eq("idle_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, ns0, ne0;
        rst = 1'b1;
        lv  = 4'h0;
        for (int k = 0; k < 4; k++) din[k] = 8'h00;

        // Reset values
        repeat (3) step();
        check_eq("rst_ser_valid", 32'(sv), 32'(4'h0));
        check_eq("rst_ser_out", 32'(so), 32'(4'b0010));
        check_eq("rst_busy", 32'(busy), 32'(4'h0));
        check_eq("rst_strobes", 32'({fs, fe}), 32'(8'h00));
        check_eq("rst_load_ready_in_rst", 32'(lr), 32'(4'h0));
        rst = 1'b0;
        @(negedge clk);
        check_eq("load_ready_after_rst", 32'(lr), 32'(4'hF));

        // Single frame 0xB4, latency and framing
        step();
        send(0, 8'hB4, w);
        @(negedge clk);
        check_eq("t1_no_bit_yet", 32'({sv[0], busy[0], lr[0]}), 32'(3'b010));
        @(negedge clk);
        check_eq("t1_first{valid,start,out}", 32'({sv[0], fs[0], so[0]}), 32'(3'b111));
        repeat (FL8 - 1) @(negedge clk);
        check_eq("t1_last{valid,end}", 32'({sv[0], fe[0]}), 32'(2'b11));
        @(negedge clk);
        check_eq("t1_after{valid,out,busy}", 32'({sv[0], so[0], busy[0]}), 32'(3'b000));
        #1;
        check_eq("t1_run_len", 32'(g_lane[0].last_run), 32'(FL8));

        // Back-to-back 0x00 then 0xFF, no bubble
        step();
        ns0 = g_lane[0].n_start;
        ne0 = g_lane[0].n_end;
        send(0, 8'h00, w);
        send(0, 8'hFF, w);
        check_eq("t2_ready_low_cycles", 32'(w), 32'(1));
        wait_idle(0);
        #1;
        check_eq("t2_run_len", 32'(g_lane[0].last_run), 32'(2 * FL8));
        check_eq("t2_starts", 32'(g_lane[0].n_start - ns0), 32'(2));
        check_eq("t2_ends", 32'(g_lane[0].n_end - ne0), 32'(2));

        // LSB first, 0x01
        step();
        send(1, 8'h01, w);
        n = 0;
        @(negedge clk);
        while (!sv[1] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check_eq("t3_start_timeout", 32'(n), 32'(0));
        check_eq("t3_first{out,start}", 32'({so[1], fs[1]}), 32'(2'b11));
        wait_idle(1);
        check_eq("t3_idle_level", 32'(so[1]), 32'(1));

        // Gap of 3 between queued frames, idle level 0 then 1
        apply_reset();
        send(2, 8'h5A, w);
        send(2, 8'hC3, w);
        wait_idle(2);
        #1;
        check_eq("t4_gap_idle0", 32'(g_lane[2].last_gap), 32'(3));
        check_eq("t4_run_idle0", 32'(g_lane[2].last_run), 32'(FL8));
        apply_reset();
        send(1, 8'h81, w);
        send(1, 8'h7E, w);
        wait_idle(1);
        #1;
        check_eq("t4_gap_idle1", 32'(g_lane[1].last_gap), 32'(3));
        check_eq("t4_run_idle1", 32'(g_lane[1].last_run), 32'(FL8));

        // Reset on the 4th bit with a second word held
        apply_reset();
        ne0 = g_lane[0].n_end;
        send(0, 8'hA5, w);
        send(0, 8'h3C, w);
        step();
        step();
        check_eq("t5_mid{valid,end,busy}", 32'({sv[0], fe[0], busy[0]}), 32'(3'b101));
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_ready_in_rst", 32'(lr[0]), 32'(0));
        step();
        check_eq("t5_abort{valid,end,busy}", 32'({sv[0], fe[0], busy[0]}), 32'(3'b000));
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_ready_after_rst", 32'(lr[0]), 32'(1));
        repeat (30) @(negedge clk);
        #1;
        check_eq("t5_no_frame_end", 32'(g_lane[0].n_end - ne0), 32'(0));
        check_eq("t5_quiet{valid,busy}", 32'({sv[0], busy[0]}), 32'(2'b00));

        // 0x07 and 0x03 (parity 1 and 0 when parity is built in)
        step();
        send(0, 8'h07, w);
        wait_idle(0);
        #1;
        check_eq("t6_run_07", 32'(g_lane[0].last_run), 32'(FL8));
        step();
        send(0, 8'h03, w);
        wait_idle(0);
        #1;
        check_eq("t6_run_03", 32'(g_lane[0].last_run), 32'(FL8));

        // Minimum width streams continuously
        step();
        send(3, 8'h02, w);
        send(3, 8'h01, w);
        send(3, 8'h03, w);
        send(3, 8'h00, w);
        wait_idle(3);
        #1;
        check_eq("t7_w2_run_len", 32'(g_lane[3].last_run), 32'(4 * FL2));

        repeat (4) @(negedge clk);
        #1;
        check_eq("pending_lane0", 32'(g_lane[0].pend), 32'(0));
        check_eq("pending_lane1", 32'(g_lane[1].pend), 32'(0));
        check_eq("pending_lane2", 32'(g_lane[2].pend), 32'(0));
        check_eq("pending_lane3", 32'(g_lane[3].pend), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
